// File: rtl/apb_node_guard.sv
// apb_node_guard: APB 1-to-N decoder with decode-miss error response, stall watchdog and sticky first-error record
module apb_node_guard #(
  parameter int NB_SLAVE       = 10,
  parameter int APB_ADDR_WIDTH = 32,
  parameter int APB_DATA_WIDTH = 32,
  parameter logic [NB_SLAVE*APB_ADDR_WIDTH-1:0] START_ADDR = '0,
  parameter logic [NB_SLAVE*APB_ADDR_WIDTH-1:0] END_ADDR   = '0,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [APB_ADDR_WIDTH-1:0]          paddr_i,
  input  logic [APB_DATA_WIDTH-1:0]          pwdata_i,
  input  logic                               pwrite_i,
  input  logic                               psel_i,
  input  logic                               penable_i,
  output logic [APB_DATA_WIDTH-1:0]          prdata_o,
  output logic                               pready_o,
  output logic                               pslverr_o,
  output logic [APB_ADDR_WIDTH-1:0]          paddr_o,
  output logic [APB_DATA_WIDTH-1:0]          pwdata_o,
  output logic                               pwrite_o,
  output logic                               penable_o,
  output logic [NB_SLAVE-1:0]                psel_o,
  input  logic [NB_SLAVE*APB_DATA_WIDTH-1:0] prdata_i,
  input  logic [NB_SLAVE-1:0]                pready_i,
  input  logic [NB_SLAVE-1:0]                pslverr_i,
  input  logic                               err_clr_i,
  output logic                               err_valid_o,
  output logic [1:0]                         err_code_o,
  output logic [APB_ADDR_WIDTH-1:0]          err_addr_o,
  output logic [7:0]                         err_cnt_o
);
  localparam int IW = NB_SLAVE > 1 ? $clog2(NB_SLAVE) : 1;
  localparam int CW = TIMEOUT_CYCLES > 0 ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] WD_LAST = CW'(TIMEOUT_CYCLES > 0 ? TIMEOUT_CYCLES - 1 : 0);
  typedef enum logic [1:0] {IDLE, ACCESS, ABORT} state_t;
  state_t state, state_nxt;
  logic [CW-1:0] wd, wd_nxt;
  logic [IW-1:0] idx;
  logic hit, act, rdy, done, timeout, abort, err_evt;
  logic [1:0] err_code_evt;
  assign paddr_o  = paddr_i;
  assign pwdata_o = pwdata_i;
  assign pwrite_o = pwrite_i;
  // descending scan so the lowest matching port is the last one written
  always_comb begin
    hit = 1'b0;
    idx = '0;
    for (int k = NB_SLAVE - 1; k >= 0; k--)
      if (paddr_i >= START_ADDR[k*APB_ADDR_WIDTH +: APB_ADDR_WIDTH] &&
          paddr_i <= END_ADDR[k*APB_ADDR_WIDTH +: APB_ADDR_WIDTH]) begin
        hit = 1'b1;
        idx = IW'(k);
      end
  end
  // an access phase seen while idle is served at once, so back-to-back transfers need no bubble
  assign act     = !rst && (state == ACCESS || (state == IDLE && psel_i && penable_i));
  assign abort   = !rst && state == ABORT;
  assign rdy     = hit ? pready_i[idx] : 1'b1;
  assign done    = act && rdy;
  assign timeout = act && !rdy && TIMEOUT_CYCLES != 0 && wd == WD_LAST;
  always_comb begin
    psel_o = '0;
    if (!rst && state != ABORT && hit) psel_o[idx] = psel_i;
    penable_o = !rst && state != ABORT && penable_i;
    pready_o  = abort || done;
    pslverr_o = abort || (done && (!hit || pslverr_i[idx]));
    prdata_o  = act && hit ? prdata_i[int'(idx)*APB_DATA_WIDTH +: APB_DATA_WIDTH] : '0;
  end
  always_comb begin
    state_nxt = IDLE;
    wd_nxt    = '0;
    if (state != ABORT && !done && timeout) state_nxt = ABORT;
    else if (state != ABORT && !done && act) begin
      state_nxt = ACCESS;
      wd_nxt    = TIMEOUT_CYCLES != 0 ? wd + 1'b1 : '0;
    end
  end
  assign err_evt      = abort || (done && (!hit || pslverr_i[idx]));
  assign err_code_evt = abort ? 2'b10 : hit ? 2'b11 : 2'b01;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      wd          <= '0;
      err_valid_o <= 1'b0;
      err_code_o  <= '0;
      err_addr_o  <= '0;
      err_cnt_o   <= '0;
    end else begin
      state <= state_nxt;
      wd    <= wd_nxt;
      // a clear empties the record first, so a coincident error becomes the new first error
      if (err_clr_i || (err_evt && !err_valid_o)) begin
        err_valid_o <= err_evt;
        err_code_o  <= err_evt ? err_code_evt : 2'b00;
        err_addr_o  <= err_evt ? paddr_i : '0;
      end
      if (err_clr_i) err_cnt_o <= {7'd0, err_evt};
      else if (err_evt && err_cnt_o != 8'hFF) err_cnt_o <= err_cnt_o + 1'b1;
    end
  end
endmodule

// File: tb/tb_apb_node_guard.sv
// tb_apb_node_guard: directed APB transfers with a queued expectation per transfer and a model of the error record
module tb_apb_node_guard;
  localparam int NS = 10, AW = 32, DW = 32, TO = 8;
  localparam logic [NS*AW-1:0] SA = {32'h1A10_0000, 32'h1A10_8000, 32'h1A10_7000, 32'h1A10_6000, 32'h1A10_5000,
                                     32'h1A10_4000, 32'h1A10_3000, 32'h1A10_2000, 32'h1A10_1000, 32'h1A10_0000};
  localparam logic [NS*AW-1:0] EA = {32'h1A10_FFFF, 32'h1A10_8FFF, 32'h1A10_7FFF, 32'h1A10_6FFF, 32'h1A10_5FFF,
                                     32'h1A10_4FFF, 32'h1A10_3FFF, 32'h1A10_2FFF, 32'h1A10_1FFF, 32'h1A10_0FFF};
  logic clk = 1'b0, rst = 1'b1;
  logic [AW-1:0] paddr_i = '0;
  logic [DW-1:0] pwdata_i = '0;
  logic pwrite_i = 1'b0, psel_i = 1'b0, penable_i = 1'b0, err_clr_i = 1'b0;
  logic [NS*DW-1:0] prdata_i;
  logic [NS-1:0] pready_i = '1, pslverr_i = '0;
  logic [DW-1:0] prdata_o, prdata_z, pwdata_o, pwdata_z;
  logic [AW-1:0] paddr_o, paddr_z, err_addr_o, err_addr_z;
  logic pready_o, pslverr_o, pwrite_o, penable_o, err_valid_o;
  logic pready_z, pslverr_z, pwrite_z, penable_z, err_valid_z;
  logic [NS-1:0] psel_o, psel_z;
  logic [1:0] err_code_o, err_code_z;
  logic [7:0] err_cnt_o, err_cnt_z;
  typedef struct {logic [NS-1:0] sel; logic [DW-1:0] data; logic err; int cyc;} exp_t;
  exp_t sb[$];
  int n_chk = 0, n_fail = 0;
  logic m_v = 1'b0;
  logic [1:0] m_c = '0;
  logic [AW-1:0] m_a = '0;
  int m_n = 0;
  always #5 clk = ~clk;
  apb_node_guard #(.NB_SLAVE(NS), .APB_ADDR_WIDTH(AW), .APB_DATA_WIDTH(DW), .START_ADDR(SA), .END_ADDR(EA),
                   .TIMEOUT_CYCLES(TO)) u_dut (
    .clk(clk), .rst(rst), .paddr_i(paddr_i), .pwdata_i(pwdata_i), .pwrite_i(pwrite_i), .psel_i(psel_i),
    .penable_i(penable_i), .prdata_o(prdata_o), .pready_o(pready_o), .pslverr_o(pslverr_o), .paddr_o(paddr_o),
    .pwdata_o(pwdata_o), .pwrite_o(pwrite_o), .penable_o(penable_o), .psel_o(psel_o), .prdata_i(prdata_i),
    .pready_i(pready_i), .pslverr_i(pslverr_i), .err_clr_i(err_clr_i), .err_valid_o(err_valid_o),
    .err_code_o(err_code_o), .err_addr_o(err_addr_o), .err_cnt_o(err_cnt_o));
  apb_node_guard #(.NB_SLAVE(NS), .APB_ADDR_WIDTH(AW), .APB_DATA_WIDTH(DW), .START_ADDR(SA), .END_ADDR(EA),
                   .TIMEOUT_CYCLES(0)) u_dut_nowd (
    .clk(clk), .rst(rst), .paddr_i(paddr_i), .pwdata_i(pwdata_i), .pwrite_i(pwrite_i), .psel_i(psel_i),
    .penable_i(penable_i), .prdata_o(prdata_z), .pready_o(pready_z), .pslverr_o(pslverr_z), .paddr_o(paddr_z),
    .pwdata_o(pwdata_z), .pwrite_o(pwrite_z), .penable_o(penable_z), .psel_o(psel_z), .prdata_i(prdata_i),
    .pready_i(pready_i), .pslverr_i(pslverr_i), .err_clr_i(err_clr_i), .err_valid_o(err_valid_z),
    .err_code_o(err_code_z), .err_addr_o(err_addr_z), .err_cnt_o(err_cnt_z));
  function automatic int mport(input logic [AW-1:0] a);
    logic [NS*AW-1:0] s, e;
    s = SA;
    e = EA;
    for (int k = 0; k < NS; k++)
      if (a >= s[k*AW +: AW] && a <= e[k*AW +: AW]) return k;
    return -1;
  endfunction
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic mupd(input logic ev, input logic [1:0] c, input logic [AW-1:0] a, input logic clr);
    if (clr) begin
      m_v = 1'b0; m_c = '0; m_a = '0; m_n = 0;
    end
    if (ev) begin
      if (!m_v) begin
        m_v = 1'b1; m_c = c; m_a = a;
      end
      if (m_n < 255) m_n++;
    end
  endtask
  task automatic chk_rec(input string tag);
    chk({tag, " err_valid"}, 64'(err_valid_o), 64'(m_v));
    chk({tag, " err_code"}, 64'(err_code_o), 64'(m_c));
    chk({tag, " err_addr"}, 64'(err_addr_o), 64'(m_a));
    chk({tag, " err_cnt"}, 64'(err_cnt_o), 64'(m_n));
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, " psel_o"}, 64'(psel_o), 64'(0));
    chk({tag, " penable_o"}, 64'(penable_o), 64'(0));
    chk({tag, " pready_o"}, 64'(pready_o), 64'(0));
    chk({tag, " pslverr_o"}, 64'(pslverr_o), 64'(0));
    chk({tag, " prdata_o"}, 64'(prdata_o), 64'(0));
  endtask
  // wt = wait states of the addressed slave; wt >= TO means it never answers in time
  task automatic apb(input string tag, input logic [AW-1:0] a, input logic wr, input int wt, input logic se,
                     input logic clr);
    exp_t x;
    int p, cyc;
    logic z;
    p = mport(a);
    x.sel = '0; x.data = '0; x.err = 1'b1; x.cyc = 1;
    if (p >= 0 && wt >= TO) x.cyc = TO + 1;
    else if (p >= 0) begin
      x.sel[p] = 1'b1; x.data = 32'hCAFE_0000 | 32'(p); x.err = se; x.cyc = wt + 1;
    end
    sb.push_back(x);
    paddr_i = a; pwrite_i = wr; pwdata_i = ~a; psel_i = 1'b1; penable_i = 1'b0;
    if (p >= 0) begin
      pready_i[p] = (wt == 0); pslverr_i[p] = se;
    end
    @(posedge clk); #1 penable_i = 1'b1;
    cyc = 1;
    z = 1'b0;
    forever begin
      @(negedge clk);
      z = z | pready_z;
      if (pready_o || cyc >= 40) break;
      @(posedge clk); #1 cyc++;
      if (p >= 0 && cyc > wt) pready_i[p] = 1'b1;
    end
    x = sb.pop_front();
    chk({tag, " cycle"}, 64'(cyc), 64'(x.cyc));
    chk({tag, " psel_o"}, 64'(psel_o), 64'(x.sel));
    chk({tag, " prdata_o"}, 64'(prdata_o), 64'(x.data));
    chk({tag, " pslverr_o"}, 64'(pslverr_o), 64'(x.err));
    if (p >= 0 && wt >= TO) chk({tag, " nowd ready"}, 64'(z), 64'(0));
    if (clr) err_clr_i = 1'b1;
    mupd(x.err, p < 0 ? 2'b01 : wt >= TO ? 2'b10 : 2'b11, a, clr);
    @(posedge clk); #1;
    psel_i = 1'b0; penable_i = 1'b0; pready_i = '1; pslverr_i = '0; err_clr_i = 1'b0;
    chk_rec(tag);
  endtask
  initial begin
    int bad;
    for (int k = 0; k < NS; k++) prdata_i[k*DW +: DW] = 32'hCAFE_0000 | 32'(k);
    paddr_i = 32'h1A10_3004; psel_i = 1'b1; penable_i = 1'b1;
    @(negedge clk);
    chk_zero("reset");
    chk_rec("reset");
    @(posedge clk); #1;
    psel_i = 1'b0; penable_i = 1'b0; rst = 1'b0;
    @(posedge clk); #1;
    apb("rd_p3", 32'h1A10_3004, 1'b0, 0, 1'b0, 1'b0);
    apb("rd_p3_end", 32'h1A10_3FFF, 1'b0, 0, 1'b0, 1'b0);
    apb("rd_p4_start", 32'h1A10_4000, 1'b0, 2, 1'b0, 1'b0);
    apb("rd_p9_only", 32'h1A10_A000, 1'b0, 1, 1'b0, 1'b0);
    apb("rd_overlap", 32'h1A10_0000, 1'b1, 0, 1'b0, 1'b0);
    apb("ready_at_thresh", 32'h1A10_2010, 1'b0, TO - 1, 1'b0, 1'b0);
    apb("miss_wr", 32'h1A20_0000, 1'b1, 0, 1'b0, 1'b0);
    apb("timeout", 32'h1A10_1010, 1'b0, 1000, 1'b0, 1'b0);
    err_clr_i = 1'b1;
    mupd(1'b0, 2'b00, '0, 1'b1);
    @(posedge clk); #1 err_clr_i = 1'b0;
    chk_rec("clear");
    apb("slverr", 32'h1A10_5008, 1'b0, 1, 1'b1, 1'b0);
    apb("miss_low", 32'h0000_0010, 1'b0, 0, 1'b0, 1'b0);
    apb("timeout_clr", 32'h1A10_1020, 1'b1, 1000, 1'b0, 1'b1);
    bad = 0;
    psel_i = 1'b1; penable_i = 1'b1;
    for (int i = 0; i < 300; i++) begin
      paddr_i = 32'h2000_0000 + 32'(i);
      @(negedge clk);
      if (!(pready_o && pslverr_o && psel_o == '0)) bad++;
      mupd(1'b1, 2'b01, paddr_i, 1'b0);
      @(posedge clk); #1;
    end
    psel_i = 1'b0; penable_i = 1'b0;
    chk("b2b miss beats not completed", 64'(bad), 64'(0));
    chk_rec("b2b");
    paddr_i = 32'h1A10_6000; psel_i = 1'b1; penable_i = 1'b0; pready_i[6] = 1'b0;
    @(posedge clk); #1 penable_i = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("stall c4 pready_o", 64'(pready_o), 64'(0));
    chk("stall c4 psel_o", 64'(psel_o), 64'(10'h040));
    rst = 1'b1;
    #1;
    mupd(1'b0, 2'b00, '0, 1'b1);
    chk_zero("mid_rst");
    chk_rec("mid_rst");
    @(posedge clk); #1;
    rst = 1'b0; psel_i = 1'b0; penable_i = 1'b0; pready_i = '1;
    @(posedge clk); #1;
    apb("post_rst", 32'h1A10_6000, 1'b0, TO - 1, 1'b0, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
